// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the stages of the simple CPU.
//   - ADDR_W / DATA_W : PC / memory address width and instruction width
//   - OP_*            : opcode values found in instr[15:12]
//   - ST_*            : fetch FSM state encoding
//   - opcode_of()     : extracts the opcode field from an instruction word
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_HALT  = 4'h7;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RUN       = 2'd1;
  localparam logic [1:0] ST_HALT_PEND = 2'd2;
  localparam logic [1:0] ST_HALTED    = 2'd3;

  function automatic logic [3:0] opcode_of(input logic [DATA_W-1:0] instr);
    return instr[DATA_W-1 -: 4];
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the simple CPU.
// Owns the program counter, addresses RAM port A (asynchronous read), captures
// the returned word into the instruction register and offers it to execute
// over a valid/ready handshake. Supports run/stop, branch redirect with flush,
// halt-opcode detection and a saturating retired-instruction counter.
//
// Ports:
//   clk          in   clock, all state on the rising edge
//   rst_n        in   synchronous active-low reset
//   run          in   level, 1 = fetch enabled
//   imem_addr    out  RAM port A address (combinational copy of pc)
//   imem_data    in   RAM port A read data, valid in the same cycle
//   ir_valid     out  instruction register holds an unconsumed instruction
//   ir_ready     in   execute stage accepts ir_data this cycle
//   ir_data      out  fetched instruction
//   ir_pc        out  address ir_data was fetched from
//   redirect     in   branch taken: flush and load redirect_pc
//   redirect_pc  in   branch target
//   halted       out  halt instruction consumed, fetching stopped
//   retired      out  handshake count, saturating at 16'hFFFF
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int               ADDR_W   = cpu_pkg::ADDR_W,
  parameter int               DATA_W   = cpu_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]       HALT_OP  = cpu_pkg::OP_HALT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output logic [15:0]       retired
);

  logic [ADDR_W-1:0] pc;
  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              handshake;
  logic              load;
  logic              load_halt;

  assign imem_addr = pc;
  assign handshake = ir_valid & ir_ready;

  // The IR refills when it is empty or being drained this cycle; a redirect
  // squashes the fetch because the word on imem_data belongs to the old path.
  assign load      = (state == ST_RUN) && (!ir_valid || ir_ready) && !redirect;
  assign load_halt = load && (imem_data[DATA_W-1 -: 4] == HALT_OP);

  // NOTE: every branch starts from the default assignment, so no latch can be
  // inferred when a state or condition is left out of the case.
  always_comb begin
    state_next = state;
    if (redirect) begin
      // In IDLE a redirect only moves the pc; elsewhere fetch restarts.
      if (state != ST_IDLE) state_next = run ? ST_RUN : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      if (run) state_next = ST_RUN;
        ST_RUN: begin
          if (load_halt) state_next = ST_HALT_PEND;
          else if (!run) state_next = ST_IDLE;
        end
        ST_HALT_PEND: if (handshake) state_next = ST_HALTED;
        ST_HALTED:    state_next = ST_HALTED;
        default:      state_next = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous, so it sits inside the clocked
  // branch and the sensitivity list holds only the clock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      ir_valid <= 1'b0;
      ir_data  <= '0;
      ir_pc    <= '0;
      halted   <= 1'b0;
      retired  <= '0;
    end else begin
      state  <= state_next;
      halted <= (state_next == ST_HALTED);

      // A handshake coinciding with a redirect still retires the instruction.
      if (handshake && (retired != 16'hFFFF)) retired <= retired + 16'd1;

      if (redirect) pc <= redirect_pc;
      else if (load && !load_halt) pc <= pc + 1'b1;

      if (redirect && (state != ST_IDLE)) ir_valid <= 1'b0;
      else if (load)                      ir_valid <= 1'b1;
      else if (handshake)                 ir_valid <= 1'b0;

      if (load) begin
        ir_data <= imem_data;
        ir_pc   <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit. A behavioural
// asynchronous-read RAM drives imem_data; inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir_data;
  logic [7:0]  ir_pc;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        halted;
  logic [15:0] retired;

  logic [15:0] mem [256];
  int checks = 0;
  int errors = 0;

  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .ir_data     (ir_data),
    .ir_pc       (ir_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted),
    .retired     (retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_addr"},    32'(imem_addr), 32'h00);
    check({tag, "_valid"},   32'(ir_valid),  32'h0);
    check({tag, "_data"},    32'(ir_data),   32'h0);
    check({tag, "_irpc"},    32'(ir_pc),     32'h00);
    check({tag, "_halted"},  32'(halted),    32'h0);
    check({tag, "_retired"}, 32'(retired),   32'h0);
  endtask

  task automatic check_ir(input string tag, input logic [15:0] data, input logic [7:0] pc);
    check({tag, "_valid"}, 32'(ir_valid), 32'h1);
    check({tag, "_data"},  32'(ir_data),  32'(data));
    check({tag, "_irpc"},  32'(ir_pc),    32'(pc));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h4000 | 16'(i);
    mem[8'h00] = 16'h1005;
    mem[8'h01] = 16'h3003;
    mem[8'h02] = 16'h20FF;
    mem[8'h03] = 16'h7000;

    rst_n = 1'b0; run = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    step(); step();
    check_reset("reset");

    // Straight-line program to the halt with the consumer always ready.
    rst_n = 1'b1; run = 1'b1; ir_ready = 1'b1;
    step();                               // IDLE -> RUN
    check("start_valid", 32'(ir_valid), 32'h0);
    step(); check_ir("seq0", 16'h1005, 8'h00);
    check("seq0_addr", 32'(imem_addr), 32'h01);
    step(); check_ir("seq1", 16'h3003, 8'h01);
    step(); check_ir("seq2", 16'h20FF, 8'h02);
    step(); check_ir("seq3", 16'h7000, 8'h03);
    check("halt_pend_halted", 32'(halted), 32'h0);
    check("halt_pend_addr", 32'(imem_addr), 32'h03);
    step();                               // halt instruction consumed
    check("halted_rise", 32'(halted), 32'h1);
    check("halted_valid", 32'(ir_valid), 32'h0);
    check("halted_retired", 32'(retired), 32'd4);
    step();
    check("halted_hold", 32'(halted), 32'h1);
    check("halted_hold_valid", 32'(ir_valid), 32'h0);

    // Redirect out of HALTED resumes fetching at the target.
    redirect = 1'b1; redirect_pc = 8'h00;
    step();
    redirect = 1'b0;
    check("unhalt_halted", 32'(halted), 32'h0);
    check("unhalt_valid", 32'(ir_valid), 32'h0);
    check("unhalt_addr", 32'(imem_addr), 32'h00);
    step(); check_ir("resume", 16'h1005, 8'h00);

    // Reset while an instruction is pending, together with a redirect.
    rst_n = 1'b0; redirect = 1'b1; redirect_pc = 8'h55;
    step();
    redirect = 1'b0;
    check_reset("midreset");

    // Backpressure: hold the first instruction for five cycles.
    rst_n = 1'b1; run = 1'b1; ir_ready = 1'b0;
    step();
    step(); check_ir("bp_first", 16'h1005, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step();
      check_ir("bp_hold", 16'h1005, 8'h00);
      check("bp_addr", 32'(imem_addr), 32'h01);
    end
    check("bp_retired", 32'(retired), 32'd0);
    ir_ready = 1'b1;
    step(); check_ir("bp_release", 16'h3003, 8'h01);
    check("bp_release_retired", 32'(retired), 32'd1);

    // Redirect coinciding with the handshake of 3003.
    redirect = 1'b1; redirect_pc = 8'h80;
    step();
    redirect = 1'b0;
    check("redir_retired", 32'(retired), 32'd2);
    check("redir_valid", 32'(ir_valid), 32'h0);
    check("redir_addr", 32'(imem_addr), 32'h80);
    step(); check_ir("redir_target", 16'h4080, 8'h80);
    check("redir_target_retired", 32'(retired), 32'd2);

    // PC wrap from FF to 00.
    redirect = 1'b1; redirect_pc = 8'hFF;
    step();
    redirect = 1'b0;
    check("wrap_retired", 32'(retired), 32'd3);
    step(); check_ir("wrap_ff", 16'h40FF, 8'hFF);
    check("wrap_addr", 32'(imem_addr), 32'h00);
    step(); check_ir("wrap_00", 16'h1005, 8'h00);
    check("wrap_00_retired", 32'(retired), 32'd4);

    // Stop mid-stream: the pending IR survives until consumed, then pc freezes.
    run = 1'b0; ir_ready = 1'b0;
    step(); check_ir("stop_pending", 16'h1005, 8'h00);
    check("stop_addr", 32'(imem_addr), 32'h01);
    ir_ready = 1'b1;
    step();
    check("stop_drained", 32'(ir_valid), 32'h0);
    check("stop_retired", 32'(retired), 32'd5);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stop_idle_valid", 32'(ir_valid), 32'h0);
      check("stop_idle_addr", 32'(imem_addr), 32'h01);
    end

    // Free-run long enough to drive retired into saturation.
    mem[8'h03] = 16'h4003;
    run = 1'b1;
    for (int i = 0; i < 65600; i++) step();
    check("sat_retired", 32'(retired), 32'hFFFF);
    check("sat_valid", 32'(ir_valid), 32'h1);
    step(); step();
    check("sat_hold", 32'(retired), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
